alt_ddrx_ddr2_odt_rank_map: RTL and testbench
=============================================

Name: alt_ddrx_ddr2_odt_rank_map

Overview:
- Sits directly downstream of the DDR2 ODT generator. It consumes the generator's rank-agnostic ODT windows (int_odt_l/int_odt_h) and produces per-chip-select ODT for the AFI.
- It delays each command's target-rank termination mask with the same latency the generator uses to start a window.
- It ANDs that mask onto the window, so only the ranks selected by the write/read ODT configuration tables terminate.
- It also holds the mask until the window closes.

Parameters:
- DWIDTH_RATIO, 2, 2 = full rate, 4 = half rate
- MEM_IF_CS_WIDTH, 2, number of chip selects (ranks), 1..4
- ADD_LAT_BUS_WIDTH, 3, width of mem_add_lat
- TCL_BUS_WIDTH, 4, width of mem_tcl; delay pipe depth = 2**TCL_BUS_WIDTH
- CTL_OUTPUT_REGD, 0, must match the generator's setting

Ports:
- ctl_clk  in  1  controller clock
- ctl_reset  in  1  asynchronous reset, active-high
- mem_tcl  in  TCL_BUS_WIDTH  CAS latency (quasi-static)
- mem_add_lat  in  ADD_LAT_BUS_WIDTH  additive latency (quasi-static)
- do_write  in  1  write command issued this cycle
- do_read  in  1  read command issued this cycle
- to_chip  in  MEM_IF_CS_WIDTH  one-hot target chip of do_write/do_read
- cfg_write_odt_chip  in  MEM_IF_CS_WIDTH*MEM_IF_CS_WIDTH  slice [r*CS+:CS] = ranks to terminate on a write to rank r
- cfg_read_odt_chip  in  MEM_IF_CS_WIDTH*MEM_IF_CS_WIDTH  same, for reads
- int_odt_l  in  1  ODT window, low half, from the generator
- int_odt_h  in  1  ODT window, high half, from the generator (ignored in full rate)
- afi_odt_l  out  MEM_IF_CS_WIDTH  per-rank ODT, low half
- afi_odt_h  out  MEM_IF_CS_WIDTH  per-rank ODT, high half (all zero in full rate)
- cmd_collision  out  1  sticky error: do_write and do_read asserted in the same cycle

Behaviour:
- Reset: all pipes, hold register, tcwl and cmd_collision are 0. Both afi_odt buses are 0.
- regd = 0 if CTL_OUTPUT_REGD = 0; otherwise 1 in full rate and 2 in half rate.
- tcwl is registered each cycle: tcwl = mem_tcl + mem_add_lat + regd - 1, truncated to TCL_BUS_WIDTH.
- Command mask, computed each cycle:
  - do_write: wmask = OR over r of (to_chip[r] ? write-table slice r : 0).
  - do_read: rmask = the same OR over the read-table slices.
  - No command: masks are 0.
  - to_chip with several bits set ORs the slices; to_chip = 0 gives a 0 mask.
- Collision: do_write and do_read together set cmd_collision, which holds until reset. The write is taken and the read is dropped.
- Delay pipes: wpipe and rpipe, each 2**TCL_BUS_WIDTH entries of MEM_IF_CS_WIDTH bits. Every cycle entry 0 loads the current mask and entry k loads entry k-1.
- Tap selection (tap_w, tap_r):
  - Full rate write: tcwl < 4 gives the current wmask; otherwise wpipe[tcwl-4].
  - Full rate read: tcwl < 3 gives the current rmask; otherwise rpipe[tcwl-3].
  - Half rate: the same thresholds, with indices (tcwl-4)/2 and (tcwl-3)/2, integer division.
  - These taps align exactly with the generator's window-start cycle.
- Window and hold:
  - win = int_odt_l | int_odt_h; tap = tap_w | tap_r.
  - hold register: next = win ? (hold | tap) : tap.
  - Effect: the mask accumulates over a window (back-to-back commands merge) and clears the cycle after the window drops.
  - A tap arriving on the cycle the window ends seeds the next window.
- Outputs, combinational:
  - afi_odt_l[i] = int_odt_l & (hold[i] | tap[i]).
  - afi_odt_h[i] = int_odt_h & (hold[i] | tap[i]) in half rate; 0 in full rate.
  - No cycle of latency is added relative to int_odt.
- A window with an all-zero mask drives no ODT.
- mem_tcl/mem_add_lat changes are legal only while idle. Outputs are undefined for 2**TCL_BUS_WIDTH cycles after a change.
- Reset mid-window forces the outputs low immediately and discards all in-flight masks.

Decomposition:
- The shared package alt_ddrx_odt_pkg holds the regd/tcwl calculation and the threshold constants (write 4, read 3), shared with the generator.
- One sub-module: alt_ddrx_odt_mask_pipe. It holds one delay pipe plus tap selection and is instantiated twice (write and read).

Test Plan:
- Full rate, CS = 2, tcl = 4, al = 0, write table r0 = 2'b01, r1 = 2'b10. Write to chip 0 -> afi_odt_l = 2'b01 exactly while int_odt_l is high (tcwl = 3, so tap = current mask); 2'b00 afterwards.
- Full rate, tcl = 5, al = 2 (tcwl = 6). Read to chip 1 with read table r1 = 2'b01 -> tap at rpipe[3], so mask 2'b01 appears 4 cycles after do_read, coincident with the window start.
- Writes to chip 0 and chip 1 two cycles apart (merged window) -> afi_odt_l = 2'b01, then 2'b11 until the window drops, then 2'b00 on the next cycle.
- Half rate, tcl = 4, al = 1 (tcwl = 4, even). Write to chip 1, mask 2'b10 -> afi_odt_h/l follow int_odt_h/l masked to 2'b10; tap index 0.
- do_write and do_read in the same cycle -> cmd_collision = 1 and stays 1; only the write mask is propagated. Assert ctl_reset -> cmd_collision = 0.
- Assert ctl_reset during an active window -> afi_odt_l/h = 0 asynchronously. The first window after reset carries only post-reset commands.

Source files
------------

// File: rtl/alt_ddrx_odt_pkg.sv
// Shared ODT timing helpers: output-register delay, write latency, and tap thresholds.
// Latency: none (constants and pure functions only).
// Backpressure: none.
package alt_ddrx_odt_pkg;

  // A write window starts 4 cycles ahead of tcwl. A read window starts 3 cycles ahead.
  localparam int unsigned ODT_WR_THRESH = 4;
  localparam int unsigned ODT_RD_THRESH = 3;

  // Extra cycles added by a registered AFI output stage: 1 full-rate beat, or 2 half-rate beats.
  function automatic int unsigned odt_regd(input int unsigned output_regd,
                                           input int unsigned dwidth_ratio);
    if (output_regd == 0) return 0;
    return (dwidth_ratio == 4) ? 2 : 1;
  endfunction

  // Write latency as seen by the ODT logic. The caller truncates it to its bus width.
  function automatic int unsigned odt_tcwl(input int unsigned tcl,
                                           input int unsigned al,
                                           input int unsigned regd);
    return tcl + al + regd - 1;
  endfunction

endpackage

// File: rtl/alt_ddrx_odt_mask_pipe.sv
// Delays a per-command rank mask and taps it where the ODT generator opens its window.
// Latency: 0 cycles below the threshold, otherwise 1..2**TCL_BUS_WIDTH cycles.
// Backpressure: none; the pipe shifts every cycle.
module alt_ddrx_odt_mask_pipe #(
  parameter int          MEM_IF_CS_WIDTH = 2,
  parameter int          TCL_BUS_WIDTH   = 4,
  parameter int          DWIDTH_RATIO    = 2,
  parameter int unsigned THRESH          = 4
) (
  input  logic                       ctl_clk,
  input  logic                       ctl_reset,
  input  logic [TCL_BUS_WIDTH-1:0]   tcwl,
  input  logic [MEM_IF_CS_WIDTH-1:0] mask,
  output logic [MEM_IF_CS_WIDTH-1:0] tap
);

  localparam int DEPTH = 2**TCL_BUS_WIDTH;

  logic [MEM_IF_CS_WIDTH-1:0] pipe [DEPTH];
  logic [TCL_BUS_WIDTH-1:0]   idx;

  // Shift register: entry 0 takes this cycle's mask, and each later entry is one cycle older.
  always_ff @(posedge ctl_clk or posedge ctl_reset) begin
    if (ctl_reset) begin
      for (int k = 0; k < DEPTH; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= mask;
      for (int k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
    end
  end

  // Tap select. Half rate covers two memory cycles per controller cycle, so the index is halved.
  always_comb begin
    idx = tcwl - TCL_BUS_WIDTH'(THRESH);
    if (DWIDTH_RATIO == 4) idx = idx >> 1;
    tap = (32'(tcwl) < THRESH) ? mask : pipe[idx];
  end

endmodule

// File: rtl/alt_ddrx_ddr2_odt_rank_map.sv
// Maps the generator's rank-agnostic ODT windows onto per-chip-select ODT, using the cfg tables.
// Latency: combinational relative to int_odt_l/h; each mask is delayed to meet its window start.
// Backpressure: none; commands are accepted every cycle.
module alt_ddrx_ddr2_odt_rank_map
  import alt_ddrx_odt_pkg::*;
#(
  parameter int DWIDTH_RATIO      = 2,
  parameter int MEM_IF_CS_WIDTH   = 2,
  parameter int ADD_LAT_BUS_WIDTH = 3,
  parameter int TCL_BUS_WIDTH     = 4,
  parameter int CTL_OUTPUT_REGD   = 0
) (
  input  logic                                       ctl_clk,
  input  logic                                       ctl_reset,
  input  logic [TCL_BUS_WIDTH-1:0]                   mem_tcl,
  input  logic [ADD_LAT_BUS_WIDTH-1:0]               mem_add_lat,
  input  logic                                       do_write,
  input  logic                                       do_read,
  input  logic [MEM_IF_CS_WIDTH-1:0]                 to_chip,
  input  logic [MEM_IF_CS_WIDTH*MEM_IF_CS_WIDTH-1:0] cfg_write_odt_chip,
  input  logic [MEM_IF_CS_WIDTH*MEM_IF_CS_WIDTH-1:0] cfg_read_odt_chip,
  input  logic                                       int_odt_l,
  input  logic                                       int_odt_h,
  output logic [MEM_IF_CS_WIDTH-1:0]                 afi_odt_l,
  output logic [MEM_IF_CS_WIDTH-1:0]                 afi_odt_h,
  output logic                                       cmd_collision
);

  localparam int          CS        = MEM_IF_CS_WIDTH;
  localparam bit          HALF_RATE = (DWIDTH_RATIO == 4);
  localparam int unsigned REGD      = odt_regd(CTL_OUTPUT_REGD, DWIDTH_RATIO);

  logic [TCL_BUS_WIDTH-1:0] tcwl;
  logic [CS-1:0]            wsel, rsel, wmask, rmask;
  logic [CS-1:0]            tap_w, tap_r, tap, hold;
  logic                     win;

  // Register the write latency so the tap mux never sees a long add chain.
  always_ff @(posedge ctl_clk or posedge ctl_reset) begin
    if (ctl_reset) tcwl <= '0;
    else           tcwl <= TCL_BUS_WIDTH'(odt_tcwl(32'(mem_tcl), 32'(mem_add_lat), REGD));
  end

  // Per-command termination mask: OR the table rows of every targeted rank. A write wins over a read.
  always_comb begin
    wsel = '0;
    rsel = '0;
    for (int r = 0; r < CS; r++) begin
      if (to_chip[r]) begin
        wsel = wsel | cfg_write_odt_chip[r*CS +: CS];
        rsel = rsel | cfg_read_odt_chip[r*CS +: CS];
      end
    end
    wmask = do_write ? wsel : '0;
    rmask = (do_read && !do_write) ? rsel : '0;
  end

  // A sticky flag records that a write and a read were issued together. It clears only on reset.
  always_ff @(posedge ctl_clk or posedge ctl_reset) begin
    if (ctl_reset)                cmd_collision <= 1'b0;
    else if (do_write && do_read) cmd_collision <= 1'b1;
  end

  alt_ddrx_odt_mask_pipe #(
    .MEM_IF_CS_WIDTH (CS),
    .TCL_BUS_WIDTH   (TCL_BUS_WIDTH),
    .DWIDTH_RATIO    (DWIDTH_RATIO),
    .THRESH          (ODT_WR_THRESH)
  ) u_wpipe (
    .ctl_clk   (ctl_clk),
    .ctl_reset (ctl_reset),
    .tcwl      (tcwl),
    .mask      (wmask),
    .tap       (tap_w)
  );

  alt_ddrx_odt_mask_pipe #(
    .MEM_IF_CS_WIDTH (CS),
    .TCL_BUS_WIDTH   (TCL_BUS_WIDTH),
    .DWIDTH_RATIO    (DWIDTH_RATIO),
    .THRESH          (ODT_RD_THRESH)
  ) u_rpipe (
    .ctl_clk   (ctl_clk),
    .ctl_reset (ctl_reset),
    .tcwl      (tcwl),
    .mask      (rmask),
    .tap       (tap_r)
  );

  assign win = int_odt_l | int_odt_h;
  assign tap = tap_w | tap_r;

  // Hold accumulates taps while the window is open. A tap on the closing cycle seeds the next window.
  always_ff @(posedge ctl_clk or posedge ctl_reset) begin
    if (ctl_reset) hold <= '0;
    else           hold <= win ? (hold | tap) : tap;
  end

  // Gate the window with the rank mask. Reset forces ODT low without waiting for a clock.
  always_comb begin
    afi_odt_l = '0;
    afi_odt_h = '0;
    if (!ctl_reset) begin
      afi_odt_l = {CS{int_odt_l}} & (hold | tap);
      if (HALF_RATE) afi_odt_h = {CS{int_odt_h}} & (hold | tap);
    end
  end

endmodule

// File: tb/tb_alt_ddrx_ddr2_odt_rank_map.sv
// Bench for the rank mapper: a vector table, hand sequences, and random traffic against a window model.
// A full-rate and a half-rate instance share the command and config inputs.
// Each instance has its own int_odt_h.
module tb_alt_ddrx_ddr2_odt_rank_map;

  logic       ctl_clk = 1'b0;
  logic       ctl_reset;
  logic [3:0] mem_tcl;
  logic [2:0] mem_add_lat;
  logic       do_write, do_read;
  logic [1:0] to_chip;
  logic [3:0] cfg_w, cfg_r;
  logic       int_odt_l, hr_odt_h, fr_odt_h;
  logic [1:0] fr_l, fr_h, hr_l, hr_h;
  logic       fr_col, hr_col;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 ctl_clk = ~ctl_clk;

  alt_ddrx_ddr2_odt_rank_map #(.DWIDTH_RATIO(2), .MEM_IF_CS_WIDTH(2), .ADD_LAT_BUS_WIDTH(3),
                               .TCL_BUS_WIDTH(4), .CTL_OUTPUT_REGD(0)) dut_fr (
    .ctl_clk(ctl_clk), .ctl_reset(ctl_reset), .mem_tcl(mem_tcl), .mem_add_lat(mem_add_lat),
    .do_write(do_write), .do_read(do_read), .to_chip(to_chip),
    .cfg_write_odt_chip(cfg_w), .cfg_read_odt_chip(cfg_r),
    .int_odt_l(int_odt_l), .int_odt_h(fr_odt_h),
    .afi_odt_l(fr_l), .afi_odt_h(fr_h), .cmd_collision(fr_col));

  alt_ddrx_ddr2_odt_rank_map #(.DWIDTH_RATIO(4), .MEM_IF_CS_WIDTH(2), .ADD_LAT_BUS_WIDTH(3),
                               .TCL_BUS_WIDTH(4), .CTL_OUTPUT_REGD(0)) dut_hr (
    .ctl_clk(ctl_clk), .ctl_reset(ctl_reset), .mem_tcl(mem_tcl), .mem_add_lat(mem_add_lat),
    .do_write(do_write), .do_read(do_read), .to_chip(to_chip),
    .cfg_write_odt_chip(cfg_w), .cfg_read_odt_chip(cfg_r),
    .int_odt_l(int_odt_l), .int_odt_h(hr_odt_h),
    .afi_odt_l(hr_l), .afi_odt_h(hr_h), .cmd_collision(hr_col));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge ctl_clk);
    #1;
  endtask

  task automatic idle(input int n);
    do_write = 0; do_read = 0; to_chip = 0; int_odt_l = 0; hr_odt_h = 0;
    for (int k = 0; k < n; k++) next_cycle();
  endtask

  // Reference model. Masks are looked up from the tables.
  // Each mask becomes visible after the delay implied by tcwl.
  // The output is the OR of all taps since the last cycle the window was closed.
  logic [1:0] hw [320];
  logic [1:0] hrd[320];
  logic       hl [320];
  logic       hh [320];

  function automatic logic [1:0] table_mask(input logic [1:0] chip, input logic [3:0] tab);
    logic [1:0] m;
    m = 2'b00;
    for (int k = 0; k < 2; k++) if (chip[k]) m = m | tab[k*2 +: 2];
    return m;
  endfunction

  function automatic int tap_delay(input bit half, input bit wr, input int tcwl);
    int th;
    th = wr ? 4 : 3;
    if (tcwl < th) return 0;
    return half ? (tcwl - th) / 2 + 1 : tcwl - th + 1;
  endfunction

  function automatic logic [1:0] model_out(input bit half, input bit is_h, input int t, input int tcwl);
    int dw, dr, s;
    logic [1:0] acc;
    dw = tap_delay(half, 1'b1, tcwl);
    dr = tap_delay(half, 1'b0, tcwl);
    s = 0;
    for (int v = t - 1; v >= 0; v--) begin
      if (!(hl[v] | (half & hh[v]))) begin s = v; break; end
    end
    acc = 2'b00;
    for (int u = s; u <= t; u++) begin
      if (u - dw >= 0) acc = acc | hw[u - dw];
      if (u - dr >= 0) acc = acc | hrd[u - dr];
    end
    if (is_h) return hh[t] ? acc : 2'b00;
    return hl[t] ? acc : 2'b00;
  endfunction

  typedef struct {
    bit         half;
    int         tcl;
    int         al;
    bit         wr;
    logic [1:0] chip;
    logic [1:0] mask;
    int         delay;
  } vec_t;

  vec_t       vt[11];
  int         d, tcwl_m;
  logic [1:0] e, m_chip[6], m_exp[6];
  logic       m_l[6];
  int         r_tcl[4], r_al[4];

  initial begin
    // write table: r1 = 10, r0 = 01. read table: r1 = 01, r0 = 11
    cfg_w = 4'b10_01;
    cfg_r = 4'b01_11;
    vt[0]  = '{0, 4, 0, 1, 2'b01, 2'b01, 0};  // tcwl 3: current mask
    vt[1]  = '{0, 5, 2, 0, 2'b10, 2'b01, 4};  // tcwl 6 read: rpipe[3]
    vt[2]  = '{0, 5, 2, 1, 2'b10, 2'b10, 3};  // tcwl 6 write: wpipe[2]
    vt[3]  = '{1, 4, 1, 1, 2'b10, 2'b10, 1};  // half, tcwl 4: index 0
    vt[4]  = '{1, 6, 1, 0, 2'b01, 2'b11, 2};  // half read, tcwl 6: index 1
    vt[5]  = '{0, 3, 0, 0, 2'b01, 2'b11, 0};  // read tcwl 2 below threshold
    vt[6]  = '{0, 4, 0, 1, 2'b11, 2'b11, 0};  // multi-hot to_chip
    vt[7]  = '{0, 4, 0, 1, 2'b00, 2'b00, 0};  // to_chip 0 gives empty mask
    vt[8]  = '{1, 7, 0, 1, 2'b01, 2'b01, 2};  // half write, tcwl 6: index 1
    vt[9]  = '{1, 5, 1, 1, 2'b01, 2'b01, 1};  // half write, tcwl 5 odd: index 0
    vt[10] = '{0, 4, 0, 0, 2'b10, 2'b01, 1};  // read exactly at threshold: rpipe[0]

    // Reset state: outputs stay low even with a window and a command present
    fr_odt_h = 0; mem_tcl = 4; mem_add_lat = 0;
    ctl_reset = 1; do_write = 1; do_read = 0; to_chip = 2'b11; int_odt_l = 1; hr_odt_h = 1;
    #2;
    chk("reset fr_l", 8'(fr_l), 8'h0);
    chk("reset hr_l", 8'(hr_l), 8'h0);
    chk("reset hr_h", 8'(hr_h), 8'h0);
    chk("reset col",  8'(fr_col), 8'h0);
    next_cycle(); next_cycle();
    ctl_reset = 0;
    idle(20);

    // Table: single command, window of 3 cycles opened at the expected delay
    for (int i = 0; i < 11; i++) begin
      mem_tcl = 4'(vt[i].tcl); mem_add_lat = 3'(vt[i].al);
      idle(20);
      d = vt[i].delay;
      for (int c = 0; c <= d + 3; c++) begin
        do_write  = (c == 0) && vt[i].wr;
        do_read   = (c == 0) && !vt[i].wr;
        to_chip   = (c == 0) ? vt[i].chip : 2'b00;
        int_odt_l = (c >= d) && (c < d + 3);
        hr_odt_h  = vt[i].half && (c >= d) && (c < d + 2);
        @(negedge ctl_clk);
        if (vt[i].half) begin
          chk($sformatf("vec%0d c%0d hr_l", i, c), 8'(hr_l), 8'(int_odt_l ? vt[i].mask : 2'b00));
          chk($sformatf("vec%0d c%0d hr_h", i, c), 8'(hr_h), 8'(hr_odt_h ? vt[i].mask : 2'b00));
        end else begin
          chk($sformatf("vec%0d c%0d fr_l", i, c), 8'(fr_l), 8'(int_odt_l ? vt[i].mask : 2'b00));
          chk($sformatf("vec%0d c%0d fr_h", i, c), 8'(fr_h), 8'h0);
        end
        next_cycle();
      end
    end

    // Merged window: writes to chip 0 then chip 1, two cycles apart
    mem_tcl = 4; mem_add_lat = 0;
    idle(20);
    m_chip = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    m_l    = '{1, 1, 1, 1, 0, 1};
    m_exp  = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00};
    for (int c = 0; c < 6; c++) begin
      do_write = (m_chip[c] != 2'b00); to_chip = m_chip[c]; int_odt_l = m_l[c];
      @(negedge ctl_clk);
      chk($sformatf("merge c%0d", c), 8'(fr_l), 8'(m_exp[c]));
      next_cycle();
    end

    // Collision: write and read together. Only the write mask is used, and the flag is sticky.
    idle(20);
    chk("col before", 8'(fr_col), 8'h0);
    do_write = 1; do_read = 1; to_chip = 2'b01; int_odt_l = 1;
    @(negedge ctl_clk);
    chk("col mask", 8'(fr_l), 8'b01);
    next_cycle();
    do_write = 0; do_read = 0; to_chip = 0; int_odt_l = 0;
    @(negedge ctl_clk);
    chk("col set fr", 8'(fr_col), 8'h1);
    chk("col set hr", 8'(hr_col), 8'h1);
    idle(5);
    chk("col sticky", 8'(fr_col), 8'h1);
    ctl_reset = 1;
    #1;
    chk("col cleared", 8'(fr_col), 8'h0);
    next_cycle();
    ctl_reset = 0;

    // Reset in mid-window drops ODT at once and discards the in-flight mask from c2
    mem_tcl = 5; mem_add_lat = 2;
    idle(20);
    for (int c = 0; c < 4; c++) begin
      do_write = (c == 0) || (c == 2);
      to_chip  = (c == 0) ? 2'b10 : (c == 2) ? 2'b01 : 2'b00;
      int_odt_l = (c == 3);
      hr_odt_h  = (c == 3);
      if (c == 3) begin
        @(negedge ctl_clk);
        chk("pre-reset win", 8'(fr_l), 8'b10);
        #1 ctl_reset = 1;
        #1;
        chk("async fr_l", 8'(fr_l), 8'h0);
        chk("async hr_l", 8'(hr_l), 8'h0);
        chk("async hr_h", 8'(hr_h), 8'h0);
      end
      next_cycle();
    end
    ctl_reset = 0; do_write = 0; to_chip = 0;
    for (int c = 0; c < 4; c++) begin
      int_odt_l = 1; hr_odt_h = 0;
      @(negedge ctl_clk);
      chk($sformatf("post-reset stale c%0d", c), 8'(fr_l), 8'h0);
      next_cycle();
    end
    idle(20);
    for (int c = 0; c <= 4; c++) begin
      do_write  = (c == 0); to_chip = (c == 0) ? 2'b01 : 2'b00;
      int_odt_l = (c == 3);
      @(negedge ctl_clk);
      chk($sformatf("post-reset new c%0d", c), 8'(fr_l), 8'(c == 3 ? 2'b01 : 2'b00));
      next_cycle();
    end

    // Random traffic against the model, under several latencies
    r_tcl = '{4, 5, 9, 2};
    r_al  = '{0, 2, 3, 0};
    for (int p = 0; p < 4; p++) begin
      mem_tcl = 4'(r_tcl[p]); mem_add_lat = 3'(r_al[p]);
      tcwl_m = (r_tcl[p] + r_al[p] - 1) & 15;
      idle(20);
      for (int t = 0; t < 300; t++) begin
        do_write = ($urandom_range(0, 3) == 0);
        do_read  = ($urandom_range(0, 3) == 0);
        to_chip  = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) int_odt_l = ~int_odt_l;
        if ($urandom_range(0, 3) == 0) hr_odt_h  = ~hr_odt_h;
        hw[t]  = do_write ? table_mask(to_chip, cfg_w) : 2'b00;
        hrd[t] = (do_read && !do_write) ? table_mask(to_chip, cfg_r) : 2'b00;
        hl[t]  = int_odt_l;
        hh[t]  = hr_odt_h;
        @(negedge ctl_clk);
        chk($sformatf("rnd p%0d t%0d fr_l", p, t), 8'(fr_l), 8'(model_out(0, 0, t, tcwl_m)));
        chk($sformatf("rnd p%0d t%0d fr_h", p, t), 8'(fr_h), 8'h0);
        e = model_out(1, 0, t, tcwl_m);
        chk($sformatf("rnd p%0d t%0d hr_l", p, t), 8'(hr_l), 8'(e));
        e = model_out(1, 1, t, tcwl_m);
        chk($sformatf("rnd p%0d t%0d hr_h", p, t), 8'(hr_h), 8'(e));
        next_cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
